// File: rtl/mu_pos_writeback_pkg.sv
// Shared types for the position writeback stage: offset/velocity payloads,
// the migrant packet carried through the outgoing FIFO, and the FSM encoding.
package mu_pos_writeback_pkg;
  localparam int OFFSET_WIDTH      = 23;
  localparam int ELEMENT_WIDTH     = 2;
  localparam int PARTICLE_ID_WIDTH = 7;
  localparam int FLOAT_WIDTH       = 32;

  typedef struct packed {
    logic [OFFSET_WIDTH-1:0] z;
    logic [OFFSET_WIDTH-1:0] y;
    logic [OFFSET_WIDTH-1:0] x;
  } offset_data_t;

  typedef struct packed {
    logic [FLOAT_WIDTH-1:0] z;
    logic [FLOAT_WIDTH-1:0] y;
    logic [FLOAT_WIDTH-1:0] x;
  } float_data_t;

  typedef struct packed {
    offset_data_t             offset;
    float_data_t              vel;
    logic [ELEMENT_WIDTH-1:0] element;
    logic [8:0]               gcell;
  } mig_pkt_t;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_DONE} wb_state_e;

  // Periodic neighbour coordinate; delta is the 2-bit two's-complement integer part.
  function automatic logic [2:0] wrap_coord(input logic [2:0] g, input logic [1:0] d,
                                            input logic [2:0] last);
    if (d == 2'b00) return g;
    if (d[1])       return (g == 3'd0) ? last : g - 3'd1;
    return (g == last) ? 3'd0 : g + 3'd1;
  endfunction
endpackage

// File: rtl/mu_pos_writeback_mig_fifo.sv
// mu_mig_fifo: synchronous FIFO of outgoing migrant packets, head presented
// combinationally; almost_full asserts with a single free entry left.
module mu_mig_fifo
  import mu_pos_writeback_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_push,
  input  mig_pkt_t i_data,
  input  logic     i_pop,
  output mig_pkt_t o_data,
  output logic     o_full,
  output logic     o_almost_full,
  output logic     o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  mig_pkt_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  always_comb begin
    o_full        = (cnt_q == CW'(DEPTH));
    o_almost_full = (cnt_q >= CW'(DEPTH - 1));
    o_empty       = (cnt_q == '0);
    do_push       = i_push && !o_full;
    do_pop        = i_pop && !o_empty;
    wr_ptr_d      = wr_ptr_q + AW'(do_push);
    rd_ptr_d      = rd_ptr_q + AW'(do_pop);
    cnt_d         = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_data = mem_q[rd_ptr_q];
endmodule

// File: rtl/mu_pos_writeback.sv
// Per-cell writeback: stayers go to the home cache, migrants to the ring FIFO,
// incoming migrants merge into the cache. MU_WB_STATS_EN adds migrant counters.
module mu_pos_writeback
  import mu_pos_writeback_pkg::*;
#(
  parameter logic [2:0] GCELL_X        = 3'b000,
  parameter logic [2:0] GCELL_Y        = 3'b000,
  parameter logic [2:0] GCELL_Z        = 3'b000,
  parameter int         NUM_CELL_X     = 3,
  parameter int         NUM_CELL_Y     = 3,
  parameter int         NUM_CELL_Z     = 3,
  parameter int         CELL_DEPTH     = 100,
  parameter int         MIG_FIFO_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_wb_start,
  input  logic                           i_mu_done,
  input  logic [3*(OFFSET_WIDTH+2)-1:0]  i_offset_ext,
  input  float_data_t                    i_vel,
  input  logic [ELEMENT_WIDTH-1:0]       i_element,
  input  logic                           i_data_valid,
  output logic                           o_ready,
  input  offset_data_t                   i_mig_in_offset,
  input  float_data_t                    i_mig_in_vel,
  input  logic [ELEMENT_WIDTH-1:0]       i_mig_in_element,
  input  logic                           i_mig_in_valid,
  output logic                           o_mig_in_ready,
  output offset_data_t                   o_mig_offset,
  output float_data_t                    o_mig_vel,
  output logic [ELEMENT_WIDTH-1:0]       o_mig_element,
  output logic [8:0]                     o_mig_gcell,
  output logic                           o_mig_valid,
  input  logic                           i_mig_ready,
  output logic [PARTICLE_ID_WIDTH-1:0]   o_wr_addr,
  output offset_data_t                   o_wr_offset,
  output float_data_t                    o_wr_vel,
  output logic [ELEMENT_WIDTH-1:0]       o_wr_element,
  output logic                           o_wr_en,
  output logic [PARTICLE_ID_WIDTH-1:0]   o_particle_num,
  output logic                           o_wb_done,
  output logic                           o_overflow
`ifdef MU_WB_STATS_EN
  ,
  output logic [PARTICLE_ID_WIDTH-1:0]   o_stat_mig_out,
  output logic [PARTICLE_ID_WIDTH-1:0]   o_stat_mig_in
`endif
);
  localparam int         EXT    = OFFSET_WIDTH + 2;
  localparam int         PIW    = PARTICLE_ID_WIDTH;
  localparam logic [2:0] LAST_X = 3'(NUM_CELL_X - 1);
  localparam logic [2:0] LAST_Y = 3'(NUM_CELL_Y - 1);
  localparam logic [2:0] LAST_Z = 3'(NUM_CELL_Z - 1);

  wb_state_e                state_q, state_d;
  logic [1:0]               quiet_q, quiet_d;
  logic [PIW-1:0]           ptr_q, ptr_d, pnum_q, pnum_d, wr_addr_q, wr_addr_d;
  logic                     ovf_q, ovf_d, wr_en_q, wr_en_d;
  offset_data_t             wr_off_q, wr_off_d, in_off;
  float_data_t              wr_vel_q, wr_vel_d;
  logic [ELEMENT_WIDTH-1:0] wr_el_q, wr_el_d;

  logic [1:0] dx, dy, dz;
  logic       is_stay, d_acc, stay_acc, min_acc, start_ok, mig_open, quiet;
  logic       fifo_push, fifo_pop, fifo_full, fifo_afull, fifo_empty;
  mig_pkt_t   push_pkt, head;

  // Each axis field is {delta[1:0], frac[OFFSET_WIDTH-1:0]}, x in the low bits.
  assign dx       = i_offset_ext[OFFSET_WIDTH +: 2];
  assign dy       = i_offset_ext[EXT + OFFSET_WIDTH +: 2];
  assign dz       = i_offset_ext[2*EXT + OFFSET_WIDTH +: 2];
  assign in_off.x = i_offset_ext[0 +: OFFSET_WIDTH];
  assign in_off.y = i_offset_ext[EXT +: OFFSET_WIDTH];
  assign in_off.z = i_offset_ext[2*EXT +: OFFSET_WIDTH];
  assign is_stay  = (dx == 2'b00) && (dy == 2'b00) && (dz == 2'b00);

  assign push_pkt.offset  = in_off;
  assign push_pkt.vel     = i_vel;
  assign push_pkt.element = i_element;
  assign push_pkt.gcell   = {wrap_coord(GCELL_Z, dz, LAST_Z),
                             wrap_coord(GCELL_Y, dy, LAST_Y),
                             wrap_coord(GCELL_X, dx, LAST_X)};

  mu_mig_fifo #(.DEPTH(MIG_FIFO_DEPTH)) u_mig_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_push        (fifo_push),
    .i_data        (push_pkt),
    .i_pop         (fifo_pop),
    .o_data        (head),
    .o_full        (fifo_full),
    .o_almost_full (fifo_afull),
    .o_empty       (fifo_empty)
  );

  // Handshakes and state-decoded outputs. Stayers own the write port, so an
  // incoming migrant is pushed back for exactly the cycle a stayer is taken.
  always_comb begin
    o_ready        = (state_q == S_ACTIVE) && !fifo_afull;
    mig_open       = (state_q == S_ACTIVE) || (state_q == S_DRAIN);
    start_ok       = i_wb_start && ((state_q == S_IDLE) || (state_q == S_DONE));
    o_wb_done      = (state_q == S_DONE);
    d_acc          = i_data_valid && o_ready;
    stay_acc       = d_acc && is_stay;
    fifo_push      = d_acc && !is_stay && !fifo_full;
    o_mig_in_ready = mig_open && !stay_acc;
    min_acc        = i_mig_in_valid && o_mig_in_ready;
    o_mig_valid    = !fifo_empty;
    fifo_pop       = o_mig_valid && i_mig_ready;
    quiet          = fifo_empty && !i_mig_in_valid;
  end

  assign o_mig_offset  = o_mig_valid ? head.offset  : '0;
  assign o_mig_vel     = o_mig_valid ? head.vel     : '0;
  assign o_mig_element = o_mig_valid ? head.element : '0;
  assign o_mig_gcell   = o_mig_valid ? head.gcell   : '0;

  always_comb begin
    state_d = state_q;
    quiet_d = '0;
    case (state_q)
      S_IDLE:   if (start_ok) state_d = S_ACTIVE;
      S_ACTIVE: if (i_mu_done && !i_data_valid) state_d = S_DRAIN;
      S_DRAIN:  if (quiet) begin
                  quiet_d = quiet_q + 2'd1;
                  if (quiet_q == 2'd3) state_d = S_DONE;
                end
      S_DONE:   state_d = start_ok ? S_ACTIVE : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // At most one of stay_acc/min_acc per cycle, so a single write register suffices.
  always_comb begin
    ptr_d     = ptr_q;
    ovf_d     = ovf_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_off_d  = wr_off_q;
    wr_vel_d  = wr_vel_q;
    wr_el_d   = wr_el_q;
    pnum_d    = (state_d == S_DONE && state_q == S_DRAIN) ? ptr_q : pnum_q;
    if (start_ok) begin
      ptr_d = '0;
      ovf_d = 1'b0;
    end else if (stay_acc || min_acc) begin
      if (ptr_q == PIW'(CELL_DEPTH)) begin
        ovf_d = 1'b1;
      end else begin
        wr_en_d   = 1'b1;
        wr_addr_d = ptr_q;
        ptr_d     = ptr_q + PIW'(1);
        wr_off_d  = stay_acc ? in_off    : i_mig_in_offset;
        wr_vel_d  = stay_acc ? i_vel     : i_mig_in_vel;
        wr_el_d   = stay_acc ? i_element : i_mig_in_element;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      quiet_q   <= '0;
      ptr_q     <= '0;
      pnum_q    <= '0;
      ovf_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_off_q  <= '0;
      wr_vel_q  <= '0;
      wr_el_q   <= '0;
    end else begin
      state_q   <= state_d;
      quiet_q   <= quiet_d;
      ptr_q     <= ptr_d;
      pnum_q    <= pnum_d;
      ovf_q     <= ovf_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_off_q  <= wr_off_d;
      wr_vel_q  <= wr_vel_d;
      wr_el_q   <= wr_el_d;
    end
  end

  assign o_wr_en        = wr_en_q;
  assign o_wr_addr      = wr_addr_q;
  assign o_wr_offset    = wr_off_q;
  assign o_wr_vel       = wr_vel_q;
  assign o_wr_element   = wr_el_q;
  assign o_particle_num = pnum_q;
  assign o_overflow     = ovf_q;

`ifdef MU_WB_STATS_EN
  logic [PIW-1:0] st_out_q, st_out_d, st_in_q, st_in_d;

  always_comb begin
    st_out_d = start_ok ? '0 : st_out_q + PIW'(fifo_pop);
    st_in_d  = start_ok ? '0 : st_in_q + PIW'(min_acc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_out_q <= '0;
      st_in_q  <= '0;
    end else begin
      st_out_q <= st_out_d;
      st_in_q  <= st_in_d;
    end
  end

  assign o_stat_mig_out = st_out_q;
  assign o_stat_mig_in  = st_in_q;
`endif
endmodule

// File: tb/tb_mu_pos_writeback.sv
// Scoreboard bench for mu_pos_writeback: a default-depth instance and a
// CELL_DEPTH=4 instance share stimulus; a monitor pops expected writes/migrants.
module tb_mu_pos_writeback;
  import mu_pos_writeback_pkg::*;
  localparam int OW  = OFFSET_WIDTH;
  localparam int EXT = 3*(OW+2);
  localparam int NC  = 3;

  logic clk = 1'b0, rst;
  always #5 clk = ~clk;

  logic i_wb_start, i_mu_done, i_data_valid, i_mig_in_valid, i_mig_ready;
  logic [EXT-1:0] i_offset_ext;
  float_data_t i_vel, i_mig_in_vel;
  logic [ELEMENT_WIDTH-1:0] i_element, i_mig_in_element;
  offset_data_t i_mig_in_offset;

  logic o_ready, o_mig_in_ready, o_mig_valid, o_wr_en, o_wb_done, o_overflow;
  offset_data_t o_mig_offset, o_wr_offset;
  float_data_t o_mig_vel, o_wr_vel;
  logic [ELEMENT_WIDTH-1:0] o_mig_element, o_wr_element;
  logic [8:0] o_mig_gcell;
  logic [PARTICLE_ID_WIDTH-1:0] o_wr_addr, o_particle_num;

  logic b_ready, b_mig_in_ready, b_mig_valid, b_wr_en, b_wb_done, b_overflow;
  offset_data_t b_mig_offset, b_wr_offset;
  float_data_t b_mig_vel, b_wr_vel;
  logic [ELEMENT_WIDTH-1:0] b_mig_element, b_wr_element;
  logic [8:0] b_mig_gcell;
  logic [PARTICLE_ID_WIDTH-1:0] b_wr_addr, b_particle_num;

  mu_pos_writeback dut (
    .clk(clk), .rst(rst), .i_wb_start(i_wb_start), .i_mu_done(i_mu_done),
    .i_offset_ext(i_offset_ext), .i_vel(i_vel), .i_element(i_element),
    .i_data_valid(i_data_valid), .o_ready(o_ready),
    .i_mig_in_offset(i_mig_in_offset), .i_mig_in_vel(i_mig_in_vel),
    .i_mig_in_element(i_mig_in_element), .i_mig_in_valid(i_mig_in_valid),
    .o_mig_in_ready(o_mig_in_ready), .o_mig_offset(o_mig_offset), .o_mig_vel(o_mig_vel),
    .o_mig_element(o_mig_element), .o_mig_gcell(o_mig_gcell), .o_mig_valid(o_mig_valid),
    .i_mig_ready(i_mig_ready), .o_wr_addr(o_wr_addr), .o_wr_offset(o_wr_offset),
    .o_wr_vel(o_wr_vel), .o_wr_element(o_wr_element), .o_wr_en(o_wr_en),
    .o_particle_num(o_particle_num), .o_wb_done(o_wb_done), .o_overflow(o_overflow)
  );

  mu_pos_writeback #(.CELL_DEPTH(4)) dut_small (
    .clk(clk), .rst(rst), .i_wb_start(i_wb_start), .i_mu_done(i_mu_done),
    .i_offset_ext(i_offset_ext), .i_vel(i_vel), .i_element(i_element),
    .i_data_valid(i_data_valid), .o_ready(b_ready),
    .i_mig_in_offset(i_mig_in_offset), .i_mig_in_vel(i_mig_in_vel),
    .i_mig_in_element(i_mig_in_element), .i_mig_in_valid(i_mig_in_valid),
    .o_mig_in_ready(b_mig_in_ready), .o_mig_offset(b_mig_offset), .o_mig_vel(b_mig_vel),
    .o_mig_element(b_mig_element), .o_mig_gcell(b_mig_gcell), .o_mig_valid(b_mig_valid),
    .i_mig_ready(i_mig_ready), .o_wr_addr(b_wr_addr), .o_wr_offset(b_wr_offset),
    .o_wr_vel(b_wr_vel), .o_wr_element(b_wr_element), .o_wr_en(b_wr_en),
    .o_particle_num(b_particle_num), .o_wb_done(b_wb_done), .o_overflow(b_overflow)
  );

  typedef struct packed {
    logic [PARTICLE_ID_WIDTH-1:0] addr;
    offset_data_t                 off;
    float_data_t                  vel;
    logic [ELEMENT_WIDTH-1:0]     el;
  } wr_exp_t;

  wr_exp_t  qa[$], qb[$];
  mig_pkt_t qm[$];
  int vectors = 0, miscompares = 0, done_a = 0, cnt = 0;

  int cur_d[3];
  offset_data_t cur_off, mi_off;
  float_data_t cur_vel, mi_vel;
  logic [ELEMENT_WIDTH-1:0] cur_el, mi_el;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s", name);
  endtask

  // Reference model: destination cell by plain modular arithmetic, cache as an append list.
  function automatic int dest(input int g, input int d);
    return (g + d + NC) % NC;
  endfunction

  task automatic model_write(input offset_data_t o, input float_data_t v, input logic [1:0] el);
    wr_exp_t e;
    e.addr = PARTICLE_ID_WIDTH'(cnt); e.off = o; e.vel = v; e.el = el;
    if (cnt < 100) qa.push_back(e);
    if (cnt < 4)   qb.push_back(e);
    cnt++;
  endtask

  task automatic model_particle();
    mig_pkt_t p;
    if (cur_d[0] == 0 && cur_d[1] == 0 && cur_d[2] == 0) begin
      model_write(cur_off, cur_vel, cur_el);
    end else begin
      p.offset = cur_off; p.vel = cur_vel; p.element = cur_el;
      p.gcell = {3'(dest(0, cur_d[2])), 3'(dest(0, cur_d[1])), 3'(dest(0, cur_d[0]))};
      qm.push_back(p);
    end
  endtask

  function automatic logic [EXT-1:0] mk_ext(input int dx, input int dy, input int dz,
                                            input offset_data_t o);
    return {2'(dz), o.z, 2'(dy), o.y, 2'(dx), o.x};
  endfunction

  task automatic new_particle(input bit stay);
    cur_off = {OW'($urandom), OW'($urandom), OW'($urandom)};
    cur_vel = {$urandom, $urandom, $urandom};
    cur_el  = 2'($urandom);
    cur_d   = '{0, 0, 0};
    if (!stay)
      while (cur_d[0] == 0 && cur_d[1] == 0 && cur_d[2] == 0)
        for (int a = 0; a < 3; a++) cur_d[a] = int'($urandom_range(0, 2)) - 1;
  endtask

  task automatic new_mig_in();
    mi_off = {OW'($urandom), OW'($urandom), OW'($urandom)};
    mi_vel = {$urandom, $urandom, $urandom};
    mi_el  = 2'($urandom);
  endtask

  task automatic present_particle();
    i_offset_ext = mk_ext(cur_d[0], cur_d[1], cur_d[2], cur_off);
    i_vel = cur_vel; i_element = cur_el; i_data_valid = 1'b1;
  endtask

  task automatic present_mig_in();
    i_mig_in_offset = mi_off; i_mig_in_vel = mi_vel; i_mig_in_element = mi_el;
    i_mig_in_valid = 1'b1;
  endtask

  task automatic idle_inputs();
    i_wb_start = 1'b0; i_mu_done = 1'b0; i_data_valid = 1'b0; i_mig_in_valid = 1'b0;
  endtask

  task automatic sync();
    @(negedge clk);
  endtask

  // Sample handshakes just before the edge and feed accepted items to the model.
  task automatic commit(output bit dacc, output bit macc);
    #4;
    dacc = i_data_valid && o_ready;
    macc = i_mig_in_valid && o_mig_in_ready;
    if (dacc) model_particle();
    if (macc) model_write(mi_off, mi_vel, mi_el);
  endtask

  task automatic start_step();
    bit da, ma;
    sync(); idle_inputs(); i_wb_start = 1'b1; commit(da, ma);
    cnt = 0;
  endtask

  task automatic send_particle();
    bit da, ma;
    int n = 0;
    da = 1'b0;
    while (!da && n < 200) begin
      sync(); idle_inputs(); present_particle(); commit(da, ma); n++;
    end
    if (!da) fail_now("send_timeout");
  endtask

  task automatic finish_step(input string tag);
    bit da, ma, seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      sync(); idle_inputs(); i_mig_ready = 1'b1; i_mu_done = 1'b1; commit(da, ma);
      seen = o_wb_done;
    end
    if (!seen) fail_now({tag, "_done_timeout"});
    chk({tag, "_num"}, o_particle_num, (cnt > 100) ? 100 : cnt);
    chk({tag, "_ovf"}, o_overflow, cnt > 100);
    chk({tag, "_num_small"}, b_particle_num, (cnt > 4) ? 4 : cnt);
    chk({tag, "_ovf_small"}, b_overflow, cnt > 4);
    sync(); idle_inputs(); commit(da, ma);
    chk({tag, "_done_pulse"}, o_wb_done, 1'b0);
    chk({tag, "_left"}, {qa.size(), qb.size(), qm.size()}, 0);
  endtask

  // Monitor: pops the scoreboard whenever a DUT emits a write or a migrant.
  wr_exp_t ea, eb;
  mig_pkt_t em;
  always begin
    @(negedge clk); #3;
    if (!rst) begin
      if (o_wr_en) begin
        if (qa.size() == 0) fail_now("wr_unexpected");
        else begin
          ea = qa.pop_front();
          chk("wr", {o_wr_addr, o_wr_offset, o_wr_vel, o_wr_element}, ea);
        end
      end
      if (b_wr_en) begin
        if (qb.size() == 0) fail_now("wr_small_unexpected");
        else begin
          eb = qb.pop_front();
          chk("wr_small", {b_wr_addr, b_wr_offset, b_wr_vel, b_wr_element}, eb);
        end
      end
      if (o_mig_valid && i_mig_ready) begin
        if (qm.size() == 0) fail_now("mig_unexpected");
        else begin
          em = qm.pop_front();
          chk("mig", {o_mig_offset, o_mig_vel, o_mig_element, o_mig_gcell}, em);
        end
      end
      if (o_wb_done) done_a++;
    end
  end

  initial begin
    bit da, ma, have_p, have_m;
    int sent, cyc, d0;
    rst = 1'b1; idle_inputs(); i_mig_ready = 1'b0;
    i_offset_ext = '0; i_vel = '0; i_element = '0;
    i_mig_in_offset = '0; i_mig_in_vel = '0; i_mig_in_element = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_outs", {o_ready, o_mig_in_ready, o_mig_valid, o_wr_en, o_wb_done, o_overflow},
        6'b0);
    chk("rst_num", o_particle_num, 0);

    // Four stayers with consecutive offsets.
    start_step();
    for (int i = 0; i < 4; i++) begin
      cur_d = '{0, 0, 0};
      cur_off = {OW'(32'h400000 + i*32'h10000), OW'(32'h400000 + i*32'h10000),
                 OW'(32'h400000 + i*32'h10000)};
      cur_vel = {$urandom, $urandom, $urandom}; cur_el = 2'(i);
      send_particle();
    end
    finish_step("stay4");

    // Single -X migrant wraps to x=2.
    start_step();
    cur_d = '{-1, 0, 0};
    cur_off = '0; cur_off.x = OW'(32'h7F0000);
    cur_vel = {$urandom, $urandom, $urandom}; cur_el = 2'd1;
    i_mig_ready = 1'b1;
    send_particle();
    finish_step("mig1");

    // Stayer and incoming migrant collide.
    start_step();
    i_mig_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin new_particle(1); send_particle(); end
    new_particle(1); new_mig_in();
    sync(); idle_inputs(); present_particle(); present_mig_in(); commit(da, ma);
    chk("coll_stay_acc", da, 1'b1);
    chk("coll_in_blocked", ma, 1'b0);
    sync(); idle_inputs(); present_mig_in(); commit(da, ma);
    chk("coll_in_acc", ma, 1'b1);
    finish_step("coll");

    // Ring back-pressure: 15 migrants stored, then drained in order.
    start_step();
    i_mig_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin new_particle(0); send_particle(); end
    sync(); idle_inputs(); commit(da, ma);
    chk("bp_ready_low", o_ready, 1'b0);
    finish_step("bp");

    // Five stayers against the depth-4 instance.
    start_step();
    for (int i = 0; i < 5; i++) begin new_particle(1); send_particle(); end
    finish_step("ovf");

    // Randomized mixed traffic.
    for (int s = 0; s < 3; s++) begin
      start_step();
      sent = 0; cyc = 0; have_p = 1'b0; have_m = 1'b0;
      while (sent < 30 && cyc < 2000) begin
        sync(); idle_inputs();
        i_mig_ready = 1'($urandom_range(0, 1));
        if (!have_p) begin new_particle($urandom_range(0, 1) == 0); have_p = 1'b1; end
        if ($urandom_range(0, 3) != 0) present_particle();
        if (!have_m && $urandom_range(0, 2) == 0) begin new_mig_in(); have_m = 1'b1; end
        if (have_m) present_mig_in();
        commit(da, ma);
        if (da) begin have_p = 1'b0; sent++; end
        if (ma) have_m = 1'b0;
        cyc++;
      end
      if (sent < 30) fail_now("rand_stall");
      finish_step("rand");
    end

    // Reset with migrants queued, then a clean step.
    start_step();
    i_mig_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin new_particle(0); send_particle(); end
    sync(); idle_inputs(); rst = 1'b1;
    qa.delete(); qb.delete(); qm.delete();
    #1;
    chk("rst_mid_mig_valid", o_mig_valid, 1'b0);
    d0 = done_a;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) begin sync(); idle_inputs(); commit(da, ma); end
    chk("rst_mid_no_done", done_a, d0);
    start_step();
    i_mig_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin new_particle(1); send_particle(); end
    finish_step("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
